qspi_line_reader: RTL and testbench

- Parametrised next-generation QSPI XIP line fetcher. Reads one aligned cache line from quad I/O flash using the Quad I/O Fast Read command (EBh) with continuous-read (mode A5h) support.
- Adds a programmable SCK divider, configurable dummy cycles, a valid/ready request handshake, minimum CS-high time, and explicit exit from continuous-read mode.
- Sits between the XIP cache line-fill logic and the flash pad mux, downstream of the flash power-on reset sequencer.

---
 rtl/qspi_line_reader.sv | 122 ++++++++++++
 tb/tb_qspi_line_reader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/qspi_line_reader.sv
// qspi_line_reader: quad I/O (EBh) XIP cache-line fetcher with continuous-read mode
module qspi_line_reader #(
   parameter int LINE_SIZE    = 16,
   parameter int CLK_DIV      = 1,
   parameter int DUMMY_CYCLES = 4,
   parameter int CSH_CYCLES   = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req,
   output logic                   ready,
   input  logic [23:0]            addr,
   input  logic                   cont_dis,
   output logic                   done,
   output logic [LINE_SIZE*8-1:0] line,
   output logic                   sck,
   output logic                   ce_n,
   input  logic [3:0]             din,
   output logic [3:0]             dout,
   output logic                   douten
);
   localparam int LW = LINE_SIZE*8;
   localparam int CW = 16;
   localparam int DW = $clog2(CLK_DIV+1);
   localparam logic [7:0] CMD_EB = 8'hEB;
   typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, CSH} state_t;
   state_t state_q, state_d, after;
   logic [CW-1:0] cnt_q, cnt_d, len;
   logic [DW-1:0] div_q, div_d;
   logic [23:0] a_q, a_d;
   logic [LW-1:0] sh_q, sh_d, line_q, line_d, swp;
   logic cdis_q, cdis_d, cont_q, cont_d, sck_q, sck_d, ce_n_q, ce_n_d, done_q, done_d;
   logic active, tick, fin;
   for (genvar g = 0; g < LINE_SIZE; g++) begin : g_swp
      assign swp[8*g +: 8] = {sh_q[8*g +: 4], sh_q[8*g+4 +: 4]};
   end
   // SCK half-period pacing, phase sequencing, pad drive and line capture
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      a_d     = a_q;
      cdis_d  = cdis_q;
      cont_d  = cont_q;
      sh_d    = sh_q;
      line_d  = line_q;
      sck_d   = sck_q;
      ce_n_d  = ce_n_q;
      done_d  = 1'b0;
      active  = state_q inside {CMD, ADDR, MODE, DUMMY, DATA};
      tick    = active && div_q == DW'(CLK_DIV-1);
      len     = state_q == CMD ? CW'(8) : state_q == ADDR ? CW'(6) : state_q == MODE ? CW'(2) :
                state_q == DUMMY ? CW'(DUMMY_CYCLES) : CW'(2*LINE_SIZE);
      after   = state_q == CMD ? ADDR : state_q == ADDR ? MODE :
                (state_q == MODE && DUMMY_CYCLES > 0) ? DUMMY : DATA;
      fin     = state_q == DATA && cnt_q == len;
      ready   = state_q == IDLE;
      douten  = state_q inside {CMD, ADDR, MODE};
      dout    = state_q == CMD  ? {3'b000, CMD_EB[~cnt_q[2:0]]} :
                state_q == ADDR ? 4'(a_q >> (5'd20 - {cnt_q[2:0], 2'b00})) :
                state_q == MODE ? (cdis_q ? 4'hF : cnt_q[0] ? 4'h5 : 4'hA) : 4'h0;
      if (active) div_d = tick ? '0 : div_q + DW'(1);
      if (state_q == IDLE && req) begin
         state_d = cont_q ? ADDR : CMD;
         a_d     = addr & ~24'(LINE_SIZE-1);
         cdis_d  = cont_dis;
         ce_n_d  = 1'b0;
         cnt_d   = '0;
         div_d   = '0;
      end else if (state_q == CSH) begin
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CW'(CSH_CYCLES-1)) state_d = IDLE;
      end else if (tick && fin) begin
         state_d = CSH;
         cnt_d   = '0;
         ce_n_d  = 1'b1;
         done_d  = 1'b1;
         line_d  = swp;
         cont_d  = ~cdis_q;
      end else if (tick && !sck_q) begin
         sck_d = 1'b1;
         if (state_q == DATA) sh_d = {din, sh_q[LW-1:4]};
      end else if (tick) begin
         sck_d = 1'b0;
         if (state_q != DATA && cnt_q == len - CW'(1)) begin
            state_d = after;
            cnt_d   = '0;
         end else cnt_d = cnt_q + CW'(1);
      end
   end
   // state register with asynchronous reset; reset drops continuous mode so the next read sends EBh
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         a_q     <= '0;
         cdis_q  <= 1'b0;
         cont_q  <= 1'b0;
         sh_q    <= '0;
         line_q  <= '0;
         sck_q   <= 1'b0;
         ce_n_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         a_q     <= a_d;
         cdis_q  <= cdis_d;
         cont_q  <= cont_d;
         sh_q    <= sh_d;
         line_q  <= line_d;
         sck_q   <= sck_d;
         ce_n_q  <= ce_n_d;
         done_q  <= done_d;
      end
   assign sck  = sck_q;
   assign ce_n = ce_n_q;
   assign done = done_q;
   assign line = line_q;
endmodule

// File: tb/tb_qspi_line_reader.sv
// tb_qspi_line_reader: randomized line reads against a quad-IO flash model, two configurations
module tb_qspi_line_reader;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int n_chk = 0, n_pass = 0, nfin = 0;
   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   function automatic logic [7:0] mem(input logic [23:0] a);
      return a[7:0] ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'h3C;
   endfunction
   for (genvar g = 0; g < 2; g++) begin : g_c
      localparam int LS = g ? 32 : 16;
      localparam int CD = g ? 3 : 1;
      localparam int DC = g ? 6 : 4;
      localparam int CS = 2;
      localparam int LW = LS*8;
      logic rst_n, req, ready, cont_dis, done, sck, ce_n, douten;
      logic [23:0] addr;
      logic [LW-1:0] line;
      logic [3:0] din, dout;
      logic [4:0] rx_q[$];
      bit fcont = 1'b0;
      qspi_line_reader #(.LINE_SIZE(LS), .CLK_DIV(CD), .DUMMY_CYCLES(DC), .CSH_CYCLES(CS)) u_dut (
         .clk(clk), .rst_n(rst_n), .req(req), .ready(ready), .addr(addr), .cont_dis(cont_dis),
         .done(done), .line(line), .sck(sck), .ce_n(ce_n), .din(din), .dout(dout), .douten(douten));
      // flash: record {douten,dout} at every SCK rise of a transaction
      always @(negedge ce_n) rx_q.delete();
      always @(posedge sck) if (!ce_n) rx_q.push_back({douten, dout});
      // flash: drive read data after each SCK fall, header length from its own mode state
      always @(negedge sck) begin
         int o, k;
         logic [23:0] fa;
         logic [7:0] b;
         o = fcont ? 0 : 8;
         k = rx_q.size() - o - 8 - DC;
         fa = '0;
         if (k >= 0 && k < 2*LS) begin
            for (int i = 0; i < 6; i++) fa = {fa[19:0], rx_q[o+i][3:0]};
            b = mem(fa + 24'(k/2));
            din = k[0] ? b[3:0] : b[7:4];
         end else din = 4'($urandom);
      end
      // flash: enter continuous mode only on mode byte A5h; the reset sequencer clears it
      always @(posedge ce_n or negedge rst_n) begin
         int o;
         o = fcont ? 0 : 8;
         if (!rst_n) fcont = 1'b0;
         else if (rx_q.size() >= o + 8) fcont = {rx_q[o+6][3:0], rx_q[o+7][3:0]} == 8'hA5;
      end
      initial begin
         int cyc, rc, nb, bad, n, hdr, lim, gap, to;
         bit ec, cd, inj;
         logic [23:0] a, al;
         logic [LW-1:0] xl, pl;
         logic [7:0] eb;
         logic [4:0] e;
         eb = 8'hEB;
         din = 4'h0;
         rst_n = 1'b0; req = 1'b0; addr = '0; cont_dis = 1'b0;
         repeat (3) @(negedge clk);
         check("rst_ready", ready, 1'b1);
         check("rst_ce_n", ce_n, 1'b1);
         check("rst_sck", sck, 1'b0);
         check("rst_done", done, 1'b0);
         check("rst_douten", {douten, dout}, 5'h0);
         check("rst_line", line, '0);
         rst_n = 1'b1;
         ec = 1'b0;
         pl = '0;
         for (int t = 0; t < 12; t++) begin
            a  = t == 0 ? 24'h001234 : t == 1 ? 24'h000040 : 24'($urandom);
            cd = t == 2 ? 1'b1 : t < 6 ? 1'b0 : $urandom_range(0, 3) == 0;
            al = a & ~24'(LS-1);
            for (int i = 0; i < LS; i++) xl[8*i +: 8] = mem(al + 24'(i));
            n = (ec ? 0 : 8) + 8 + DC + 2*LS;
            hdr = n - 2*LS;
            lim = 2*(n+2)*CD + 20;
            to = 0;
            while (!ready && to < 100) begin @(negedge clk); to++; end
            check("ready_wait", to < 100, 1'b1);
            req = 1'b1; addr = a; cont_dis = cd;
            @(negedge clk);
            req = 1'b0; addr = 24'($urandom); cont_dis = 1'($urandom);
            check("accept_ce_n", {ce_n, ready}, 2'b00);
            cyc = 0; rc = -1; bad = 0; inj = 1'b0;
            while (cyc < lim) begin
               @(negedge clk);
               cyc++;
               if (rc < 0 && sck) rc = cyc;
               if (done) break;
               if (ready || line !== pl) bad++;
               if (t == 4 && !inj && rx_q.size() == hdr + 5) begin
                  req = 1'b1; addr = a ^ 24'h000800; inj = 1'b1;
               end else req = 1'b0;
               if (t == 5 && rx_q.size() == hdr + 5) break;
            end
            req = 1'b0;
            check("busy_stable", bad, 0);
            if (t == 5) begin
               rst_n = 1'b0;
               #1;
               check("mid_rst_ce_n", ce_n, 1'b1);
               check("mid_rst_sck", sck, 1'b0);
               check("mid_rst_done_ready", {done, ready}, 2'b01);
               check("mid_rst_pads", {douten, dout, line}, '0);
               @(negedge clk);
               rst_n = 1'b1;
               ec = 1'b0;
               pl = '0;
            end else begin
               check("done_seen", done, 1'b1);
               check("sck_cycles", rx_q.size(), n);
               check("rise_to_done", cyc - rc, 2*n*CD);
               check("line", line, xl);
               nb = 0;
               for (int i = 0; i < rx_q.size() && i < n; i++) begin
                  int j;
                  j = ec ? i + 8 : i;
                  e = j < 8  ? {2'b10, 2'b00, eb[7-j]} :
                      j < 14 ? {1'b1, al[4*(13-j) +: 4]} :
                      j < 16 ? {1'b1, cd ? 4'hF : j == 14 ? 4'hA : 4'h5} : 5'h00;
                  if (j < 16 + DC ? rx_q[i] !== e : rx_q[i][4] !== 1'b0) nb++;
               end
               check("pad_sequence", nb, 0);
               nb = 0;
               for (int i = 0; i < CS; i++) begin
                  if (i > 0) @(negedge clk);
                  if (ready || !ce_n || sck || (i > 0 && done)) nb++;
               end
               @(negedge clk);
               check("csh_hold", nb, 0);
               check("csh_ready", ready, 1'b1);
               ec = ~cd;
               pl = xl;
               gap = t == 4 ? 8 : 0;
               nb = 0;
               for (int i = 0; i < gap; i++) begin
                  @(negedge clk);
                  if (!ce_n || done || !ready) nb++;
               end
               if (t == 4) check("no_replay", nb, 0);
            end
         end
         nfin++;
      end
   end
   initial begin
      int w;
      w = 0;
      while (nfin < 2 && w < 60000) begin @(negedge clk); w++; end
      check("finish_timeout", nfin, 2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
